// File: rtl/top_addrmap_pkg.sv
// top_addrmap_pkg
//   Register map constants for the TOP address map: base address, total size,
//   STATUS entry count/stride, per-entry address helper, and the STATUS.state
//   field encoding. Shared by the responder RTL and anything that needs the map.
package top_addrmap_pkg;

    localparam logic [31:0] TOP_BASE_ADDR     = 32'h0000_0000;
    localparam int unsigned TOP_STATUS_NUM    = 2;
    localparam int unsigned TOP_STATUS_STRIDE = 4;
    localparam int unsigned TOP_SIZE          = TOP_STATUS_NUM * TOP_STATUS_STRIDE;

    // Absolute byte address of STATUS[idx].
    function automatic logic [31:0] TOP_STATUS_BASE_ADDR(input int unsigned idx);
        return TOP_BASE_ADDR + 32'(idx * TOP_STATUS_STRIDE);
    endfunction

    // STATUS.state field encoding (bit 0 of each STATUS register).
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/top_status_entry.sv
// top_status_entry
//   One STATUS entry: IDLE/BUSY FSM, one-cycle start pulse on IDLE->BUSY, and
//   (when TOP_REGS_BUSY_CNT_EN is defined) a saturating 16-bit busy counter.
//
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     wr_en_i       : decoded write to this entry with byte lane 0 enabled
//     wr_bit_i      : write data bit 0 (1 = start, 0 = cancel)
//     done_i        : one-cycle job-finished pulse from the tracked unit
//     state_o       : 1 while BUSY (straight from the state register)
//     start_o       : one-cycle pulse, registered alongside the IDLE->BUSY update
//     cnt_o         : busy cycle count (0 when the counter is not built)
//
//   Optional feature macro: TOP_REGS_BUSY_CNT_EN.
module top_status_entry
    import top_addrmap_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic        wr_bit_i,
    input  logic        done_i,
    output logic        state_o,
    output logic        start_o,
    output logic [15:0] cnt_o
);

    state_e state_q;
    logic   start_q;
    logic   go;

    assign go = wr_en_i && wr_bit_i;

    // In BUSY, done has priority over any same-cycle write; a write of 1 is
    // ignored anyway and a write of 0 cancels. In IDLE, done belongs to no job
    // and is ignored, so a same-cycle write of 1 still starts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q <= BUSY;
                        start_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (done_i || (wr_en_i && !wr_bit_i)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o = (state_q == BUSY);
    assign start_o = start_q;

`ifdef TOP_REGS_BUSY_CNT_EN
    logic [15:0] cnt_q;

    // Counts every clock edge spent in BUSY (including the exit edge), so a job
    // that stays BUSY for N cycles reads back N.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && go) begin
            cnt_q <= '0;
        end else if (state_q == BUSY && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: rtl/top_regs.sv
// top_regs
//   Memory-mapped responder for the TOP register map. Decodes a single-cycle
//   request/grant bus onto NumStatus STATUS registers and drives start/done
//   handshakes with the units those entries track.
//
//   Bus handshake: gnt_o mirrors req_i, so every request is accepted in the
//   cycle it is presented. Exactly one cycle later rvalid_o is high for one
//   cycle; err_o and rdata_o are meaningful only while rvalid_o is high. There
//   is no response backpressure; back-to-back requests give back-to-back
//   responses.
//
//   Ports:
//     clk_i, rst_ni        : clock, asynchronous active-low reset
//     req_i / gnt_o        : request / grant (combinational)
//     we_i, addr_i, be_i   : write enable, byte address, byte enables
//     wdata_i              : write data (only bit 0 is meaningful)
//     rvalid_o, rdata_o    : registered response valid / read data
//     err_o                : error response (unmapped or misaligned access)
//     state_o[NumStatus]   : per-entry BUSY bit, from the entry state registers
//     start_o[NumStatus]   : per-entry one-cycle start pulse
//     done_i[NumStatus]    : per-entry job-finished pulse
//
//   Optional feature macro: TOP_REGS_BUSY_CNT_EN (busy counter at bits 31:16).
module top_regs
    import top_addrmap_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(TOP_BASE_ADDR),
    parameter int unsigned          NumStatus = TOP_STATUS_NUM
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic [NumStatus-1:0] state_o,
    output logic [NumStatus-1:0] start_o,
    input  logic [NumStatus-1:0] done_i
);

    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] idx;
    logic                 hit;
    logic [NumStatus-1:0] wr_en;
    logic [15:0]          cnt [NumStatus];
    logic [31:0]          rd_val;
    logic                 unused_bits;

    assign gnt_o = req_i;

    // Addresses below BaseAddr wrap to a huge offset and fail the size check.
    assign off = addr_i - BaseAddr;
    assign idx = off >> 2;
    assign hit = (off < AddrWidth'(TOP_SIZE)) && (off[1:0] == 2'b00) &&
                 (idx < AddrWidth'(NumStatus));

    // Only bit 0 of each register is writable.
    assign unused_bits = ^{wdata_i[31:1], be_i[3:1]};

    for (genvar i = 0; i < NumStatus; i++) begin : g_entry
        assign wr_en[i] = req_i && we_i && hit && be_i[0] && (idx == AddrWidth'(i));

        top_status_entry u_entry (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .wr_en_i  (wr_en[i]),
            .wr_bit_i (wdata_i[0]),
            .done_i   (done_i[i]),
            .state_o  (state_o[i]),
            .start_o  (start_o[i]),
            .cnt_o    (cnt[i])
        );
    end

    // Built from the current register values, so a read returns the value as it
    // was before any update happening on the same edge.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NumStatus; i++) begin
            if (idx == AddrWidth'(i)) begin
                rd_val = {cnt[i], 15'd0, state_o[i]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i && !hit;
            rdata_o  <= (req_i && !we_i && hit) ? rd_val : '0;
        end
    end

endmodule

// File: doc/top_regs.md
# top_regs

Memory-mapped responder for the TOP register map generated by PeakRDL-rawheader into top_addrmap_pkg. It is the hardware end of the map that software drives through TOP_STATUS_BASE_ADDR(). It decodes a single-cycle request/grant bus and holds TOP_STATUS_NUM status registers, each with a state_e field (IDLE/BUSY). It exchanges start/done handshakes with the hardware units that the status entries track.

## Interface
- BaseAddr, default TOP_BASE_ADDR: absolute base of the map.
- AddrWidth, default 32: bus address width.
- NumStatus, default TOP_STATUS_NUM (2): number of STATUS entries; stride 4 bytes.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- req_i, in, 1: bus request.
- gnt_o, out, 1: grant.
- we_i, in, 1: write enable.
- addr_i, in, AddrWidth: byte address.
- be_i, in, 4: byte enables.
- wdata_i, in, 32: write data.
- rvalid_o, out, 1: response valid.
- rdata_o, out, 32: read data.
- err_o, out, 1: error response, qualified by rvalid_o.
- state_o, out, NumStatus: current state bit per entry (1 = BUSY).
- start_o, out, NumStatus: one-cycle pulse when an entry enters BUSY.
- done_i, in, NumStatus: one-cycle pulse from hardware that the job has finished.

## Operation
- gnt_o = req_i, combinational. The block always accepts a request.
- Decode: off = addr_i - BaseAddr.
  - Hit when off < TOP_SIZE and off[1:0] == 0.
  - Index i = off >> 2, and i must be < NumStatus.
  - Any other access is an error: err_o = 1, rdata_o = 0, no state change.
- Register layout of STATUS[i]:
  - bit 0: state (RW).
  - bits 15:1: read as 0; writes ignored.
  - bits 31:16: busy cycle count, RO. Present only with the macro in ## Configuration; otherwise 0.
- A write affects bit 0 only when be_i[0] = 1. With be_i[0] = 0 the write is accepted, returns no error, and has no effect.
- Per-entry FSM, states IDLE and BUSY:
  - IDLE -> BUSY: SW writes 1. start_o[i] pulses in the same cycle the state register updates.
  - BUSY -> IDLE: done_i[i] = 1, or SW writes 0 (cancel). A cancel produces no start_o pulse.
  - Writing 1 while BUSY is ignored; there is no restart.
  - done_i while IDLE is ignored.
  - Write 1 in the same cycle as done_i[i] while BUSY: done wins, and the next state is IDLE.
  - Write 1 in the same cycle as done_i[i] while IDLE: the entry goes to BUSY. The done pulse is ignored because it belongs to no job.
- Reads return the register value as it was before any same-cycle update.

## Timing
- Response latency is exactly 1 cycle: rvalid_o is high in the cycle after req_i && gnt_o, and lasts one cycle.
- Back-to-back requests give back-to-back responses. There is no response backpressure.
- A write updates state in the cycle after grant. state_o reflects the new value in that same cycle, from a register, with no combinational path from the bus.
- done_i sampled in cycle N: state_o is low in cycle N+1.
- Reset values:
  - rvalid_o = 0, err_o = 0, rdata_o = 0.
  - All entries IDLE; state_o = 0; start_o = 0.
  - Counters = 0.
- Reset asserted mid-transaction: any pending response is dropped and no rvalid_o is issued.

## Configuration
- TOP_REGS_BUSY_CNT_EN defined: each entry has a 16-bit counter.
  - Cleared on IDLE->BUSY.
  - Increments every cycle while BUSY and saturates at 0xFFFF.
  - Holds its value in IDLE.
  - Readable at bits 31:16.
- TOP_REGS_BUSY_CNT_EN not defined: no counter logic; bits 31:16 read 0.

## Structure
- All map constants come from top_addrmap_pkg: TOP_BASE_ADDR, TOP_SIZE, TOP_STATUS_BASE_ADDR(), TOP_STATUS_NUM and state_e. The block defines no duplicate constants.
- One sub-module, top_status_entry, instantiated NumStatus times. It holds the FSM, the start pulse and the optional counter.
- top_regs contains the decode logic, the response register and the read mux.

## Test plan
- Reset, then read 0x0 and 0x4 -> rvalid_o one cycle later; rdata_o = 0x0; err_o = 0.
- Write 0x1 to 0x4 with be_i = 0xF -> start_o = 0b10 for exactly one cycle; state_o = 0b10; a read of 0x4 returns bit0 = 1. Pulse done_i[1] -> state_o = 0b00 one cycle later.
- Read 0x8 and read 0x2 -> err_o = 1, rdata_o = 0. A write of 0x1 to 0x8 changes no state.
- With STATUS[0] BUSY, assert a write of 0x1 to 0x0 and done_i[0] in the same cycle -> STATUS[0] = IDLE and no start_o pulse.
- Write 0x1 to 0x0 with be_i = 0xE -> no change. Write 0x0 to a BUSY entry -> IDLE with no start_o pulse.
- With TOP_REGS_BUSY_CNT_EN: start STATUS[0], pulse done_i[0] 10 cycles later, read 0x0 -> bits 31:16 = 10. Holding BUSY for 70000 cycles -> bits 31:16 = 0xFFFF.
